fd_decode: RTL and testbench
============================

# fd_decode

F/D pipeline register plus branch/jump resolution for the five-stage MIPS core. Captures the instruction word and PC produced by fetch each cycle, holds them on stall, and resolves beq/bne/j/jal/jr in D. Drives `branch`/`DnPC` back to fetch so the instruction after the delay slot comes from the resolved target. Sits between the fetch stage and the D/E register; operands arrive already forwarded from the hazard unit.

## Interface
- `RESET_PC`, 32'h0000_0000: value of `D_PC` after reset (bubble PC).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  hold the F/D register (same signal as fetch `pause`).
- `F_ins`  in  32  instruction word from fetch.
- `F_PC`  in  32  PC of `F_ins`.
- `D_rs_val`  in  32  forwarded GPR[rs] for the instruction in D.
- `D_rt_val`  in  32  forwarded GPR[rt] for the instruction in D.
- `D_ins`  out  32  registered instruction in D.
- `D_PC`  out  32  registered PC in D.
- `D_rs`, `D_rt`  out  5  `D_ins[25:21]`, `D_ins[20:16]`, to GPR read ports / hazard unit.
- `D_link`  out  32  `D_PC + 8`, link value for jal.
- `branch`  out  1  redirect fetch to `DnPC` on the next edge.
- `DnPC`  out  32  resolved target.

## Operation
- F/D register: on each edge, reset -> `D_ins`=0 (sll $0 nop), `D_PC`=`RESET_PC`; else if `stall` -> hold; else load `F_ins`, `F_PC`. Reset has priority over stall.
- Decode of `D_ins` (combinational from registered state):
  - beq (op 6'b000100): taken iff `D_rs_val == D_rt_val`.
  - bne (op 6'b000101): taken iff values differ.
  - j (op 6'b000010), jal (op 6'b000011): always taken.
  - jr (op 0, funct 6'b001000): always taken.
  - anything else: `branch`=0.
- Targets, all 32-bit, wrap modulo 2^32:
  - beq/bne: `D_PC + 4 + (sext(imm16) << 2)`.
  - j/jal: `{pc4[31:28], imm26, 2'b00}`, where `pc4 = D_PC + 4`.
  - jr: `D_rs_val`.
- `DnPC` equals `D_PC + 4` when no control instruction is decoded. It is never X.
- Delay slot: the instruction fetched while the branch sits in D is always executed. This block does no flush.
- `branch` is not gated by `stall`. Fetch's PC is held while stalled, so the redirect takes effect on the first unstalled edge. The hazard unit guarantees the operands are valid by then.

## Timing
- F -> D latency: 1 cycle. `D_*` reflect the `F_*` values present at the previous unstalled edge.
- `branch`/`DnPC` are valid in the same cycle the instruction is in D. Fetch samples them at the following edge, one cycle after the delay slot entered F.
- Reset mid-operation: on the next edge D becomes a nop, so `branch`=0 and `DnPC`=`RESET_PC`+4.
- Stall asserted for N cycles: `D_ins`/`D_PC` constant for N edges. `branch` can change only through `D_rs_val`/`D_rt_val` updates.
- Simultaneous `reset` and `stall`: reset wins.

## Structure
- Shared package `mips_pkg`:
  - opcode/funct constants `OP_BEQ`, `OP_BNE`, `OP_J`, `OP_JAL`, `OP_SPECIAL`, `FN_JR`.
  - `NOP_WORD`.
  - `IM_RESET_PC` (32'h0000_3000), also used by fetch.
- One sub-module: `br_unit`, purely combinational. Inputs are `D_ins`, `D_PC`, `D_rs_val`, `D_rt_val`; outputs are `branch`, `DnPC`. The top holds the F/D register and the field slicing.

## Test plan
- Reset held 2 cycles with `F_ins`=0x10850003 -> `D_ins`=0, `D_PC`=0, `branch`=0, `DnPC`=0x4.
- beq taken: load `F_ins`=0x10850003 at `F_PC`=0x3000; next cycle `D_rs_val`=`D_rt_val`=7 -> `branch`=1, `DnPC`=0x3010. Change `D_rt_val` to 8 -> `branch`=0.
- Negative offset: bne 0x1485FFFF at `D_PC`=0x3020 with rs=1, rt=2 -> `branch`=1, `DnPC`=0x3020.
- jal 0x0C000C00 at `D_PC`=0x3004 -> `branch`=1, `DnPC`=0x3000, `D_link`=0x300C, `D_rs`=0, `D_rt`=0.
- jr 0x03E00008 with `D_rs_val`=0x3040 -> `D_rs`=31, `branch`=1, `DnPC`=0x3040.
- Stall for 2 cycles while `F_ins` changes every cycle -> `D_ins`/`D_PC` unchanged. The first unstalled edge loads the current `F_ins`. `reset` asserted together with `stall` -> nop loaded.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: field widths, opcode/funct encodings, reset values
// and the instruction-class decode used by the D-stage branch resolver.
package mips_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned OP_W  = 6;
   localparam int unsigned IMM_W = 16;
   localparam int unsigned TGT_W = 26;

   localparam logic [OP_W-1:0] OP_SPECIAL = 6'b000000;
   localparam logic [OP_W-1:0] OP_J       = 6'b000010;
   localparam logic [OP_W-1:0] OP_JAL     = 6'b000011;
   localparam logic [OP_W-1:0] OP_BEQ     = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE     = 6'b000101;
   localparam logic [OP_W-1:0] FN_JR      = 6'b001000;

   localparam logic [XLEN-1:0] NOP_WORD    = 32'h0000_0000;
   localparam logic [XLEN-1:0] IM_RESET_PC = 32'h0000_3000;

   // Control-transfer class of the instruction sitting in D.
   typedef enum logic [2:0] {
      CTL_NONE,
      CTL_BEQ,
      CTL_BNE,
      CTL_JUMP,
      CTL_JR
   } ctl_e;

   // I-type view of an instruction word; funct overlaps imm[5:0] for R-type.
   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [IMM_W-1:0] imm;
   } itype_t;

   function automatic ctl_e classify(input logic [XLEN-1:0] ins);
      itype_t f;
      ctl_e   c;
      f = itype_t'(ins);
      c = CTL_NONE;
      unique case (f.op)
         OP_BEQ:     c = CTL_BEQ;
         OP_BNE:     c = CTL_BNE;
         OP_J,
         OP_JAL:     c = CTL_JUMP;
         OP_SPECIAL: c = (f.imm[OP_W-1:0] == FN_JR) ? CTL_JR : CTL_NONE;
         default:    c = CTL_NONE;
      endcase
      return c;
   endfunction

   // Word-aligned, sign-extended branch displacement.
   function automatic logic [XLEN-1:0] branch_offset(input logic [IMM_W-1:0] imm);
      return {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/br_unit.sv
// Combinational beq/bne/j/jal/jr resolution for the instruction held in D.
// DnPC falls back to the sequential PC whenever nothing is taken.
module br_unit
   import mips_pkg::*;
(
   input  logic [XLEN-1:0] D_ins,
   input  logic [XLEN-1:0] D_PC,
   input  logic [XLEN-1:0] D_rs_val,
   input  logic [XLEN-1:0] D_rt_val,
   output logic            branch,
   output logic [XLEN-1:0] DnPC
);

   ctl_e            ctl;
   logic [XLEN-1:0] pc4;
   logic [XLEN-1:0] br_tgt;
   logic [XLEN-1:0] j_tgt;
   logic            ops_eq;

   always_comb begin
      ctl    = classify(D_ins);
      pc4    = D_PC + XLEN'(4);
      br_tgt = pc4 + branch_offset(D_ins[IMM_W-1:0]);
      j_tgt  = {pc4[XLEN-1:TGT_W+2], D_ins[TGT_W-1:0], 2'b00};
      ops_eq = (D_rs_val == D_rt_val);
   end

   // Taken decision and target select; defaults give the fall-through PC.
   always_comb begin
      branch = 1'b0;
      DnPC   = pc4;
      unique case (ctl)
         CTL_BEQ: begin
            if (ops_eq) begin
               branch = 1'b1;
               DnPC   = br_tgt;
            end
         end
         CTL_BNE: begin
            if (!ops_eq) begin
               branch = 1'b1;
               DnPC   = br_tgt;
            end
         end
         CTL_JUMP: begin
            branch = 1'b1;
            DnPC   = j_tgt;
         end
         CTL_JR: begin
            branch = 1'b1;
            DnPC   = D_rs_val;
         end
         default: begin
            branch = 1'b0;
            DnPC   = pc4;
         end
      endcase
   end

endmodule

// File: rtl/fd_decode.sv
// F/D pipeline register with register-field slicing and D-stage branch resolution.
// Reset loads a nop bubble; stall holds the captured instruction and PC.
module fd_decode
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic [XLEN-1:0]       F_ins,
   input  logic [XLEN-1:0]       F_PC,
   input  logic [XLEN-1:0]       D_rs_val,
   input  logic [XLEN-1:0]       D_rt_val,
   output logic [XLEN-1:0]       D_ins,
   output logic [XLEN-1:0]       D_PC,
   output logic [REG_W-1:0]      D_rs,
   output logic [REG_W-1:0]      D_rt,
   output logic [XLEN-1:0]       D_link,
   output logic                  branch,
   output logic [XLEN-1:0]       DnPC
);

   itype_t fields;

   // Reset outranks stall so a stalled pipe can still be flushed to a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         D_ins <= NOP_WORD;
         D_PC  <= RESET_PC;
      end else if (!stall) begin
         D_ins <= F_ins;
         D_PC  <= F_PC;
      end
   end

   always_comb begin
      fields = itype_t'(D_ins);
      D_rs   = fields.rs;
      D_rt   = fields.rt;
      D_link = D_PC + XLEN'(8);
   end

   br_unit u_br_unit (
      .D_ins    (D_ins),
      .D_PC     (D_PC),
      .D_rs_val (D_rs_val),
      .D_rt_val (D_rt_val),
      .branch   (branch),
      .DnPC     (DnPC)
   );

endmodule

// File: tb/tb_fd_decode.sv
// Self-checking bench for fd_decode: directed vector table, stall/reset sequences,
// and randomized traffic against an architectural model of branch resolution.
module tb_fd_decode;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [31:0] F_ins;
   logic [31:0] F_PC;
   logic [31:0] D_rs_val;
   logic [31:0] D_rt_val;
   logic [31:0] D_ins;
   logic [31:0] D_PC;
   logic [4:0]  D_rs;
   logic [4:0]  D_rt;
   logic [31:0] D_link;
   logic        branch;
   logic [31:0] DnPC;

   int n_checks = 0;
   int n_fail   = 0;

   fd_decode #(.RESET_PC(32'h0000_0000)) dut (
      .clk      (clk),
      .reset    (reset),
      .stall    (stall),
      .F_ins    (F_ins),
      .F_PC     (F_PC),
      .D_rs_val (D_rs_val),
      .D_rt_val (D_rt_val),
      .D_ins    (D_ins),
      .D_PC     (D_PC),
      .D_rs     (D_rs),
      .D_rt     (D_rt),
      .D_link   (D_link),
      .branch   (branch),
      .DnPC     (DnPC)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic        exp_br;
      logic        chk_npc;
      logic [31:0] exp_npc;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Architectural reference: what fetch should do next for instruction ins at pc.
   function automatic void model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic br, output logic known, output logic [31:0] npc);
      int unsigned op, fn;
      logic [31:0] seq, disp;
      op    = int'(ins >> 26);
      fn    = int'(ins & 32'h3F);
      seq   = pc + 32'd4;
      disp  = 32'($signed(ins[15:0])) * 32'd4;
      br    = 1'b0;
      known = 1'b1;
      npc   = seq;
      if (op == 4 || op == 5) begin
         br = (op == 4) ? (a == b) : (a != b);
         known = br;
         npc = seq + disp;
      end else if (op == 2 || op == 3) begin
         br  = 1'b1;
         npc = (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
      end else if (op == 0 && fn == 8) begin
         br  = 1'b1;
         npc = a;
      end
   endfunction

   initial begin
      logic        mbr, mknown;
      logic [31:0] mnpc, exp_ins, exp_pc, w, a, b;

      reset = 1'b1; stall = 1'b0;
      F_ins = 32'h1085_0003; F_PC = 32'h0000_3000;
      D_rs_val = 32'd7; D_rt_val = 32'd7;

      // Reset held two cycles while a taken beq sits on the fetch side.
      step(); step();
      check("reset D_ins",  D_ins, 32'h0);
      check("reset D_PC",   D_PC,  32'h0);
      check("reset branch", 32'(branch), 32'h0);
      check("reset DnPC",   DnPC,  32'h4);
      reset = 1'b0;

      vecs.push_back('{"beq taken",      32'h1085_0003, 32'h0000_3000, 32'd7, 32'd7, 1'b1, 1'b1, 32'h0000_3010});
      vecs.push_back('{"beq not taken",  32'h1085_0003, 32'h0000_3000, 32'd7, 32'd8, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{"bne neg off",    32'h1485_FFFF, 32'h0000_3020, 32'd1, 32'd2, 1'b1, 1'b1, 32'h0000_3020});
      vecs.push_back('{"bne equal",      32'h1485_FFFF, 32'h0000_3020, 32'd5, 32'd5, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{"jal",            32'h0C00_0C00, 32'h0000_3004, 32'd0, 32'd0, 1'b1, 1'b1, 32'h0000_3000});
      vecs.push_back('{"jr ra",          32'h03E0_0008, 32'h0000_3008, 32'h3040, 32'd9, 1'b1, 1'b1, 32'h0000_3040});
      vecs.push_back('{"j high region",  32'h0800_0001, 32'hF000_0000, 32'd0, 32'd0, 1'b1, 1'b1, 32'hF000_0004});
      vecs.push_back('{"j pc4 carry",    32'h0800_0010, 32'h1FFF_FFFC, 32'd0, 32'd0, 1'b1, 1'b1, 32'h2000_0040});
      vecs.push_back('{"beq wrap",       32'h1000_0001, 32'hFFFF_FFF8, 32'd3, 32'd3, 1'b1, 1'b1, 32'h0000_0000});
      vecs.push_back('{"add no ctl",     32'h0085_1020, 32'h0000_3100, 32'd1, 32'd1, 1'b0, 1'b1, 32'h0000_3104});
      vecs.push_back('{"jalr not jr",    32'h03E0_F809, 32'h0000_3200, 32'd1, 32'd1, 1'b0, 1'b1, 32'h0000_3204});

      foreach (vecs[i]) begin
         F_ins = vecs[i].ins; F_PC = vecs[i].pc; stall = 1'b0;
         step();
         D_rs_val = vecs[i].rs_val; D_rt_val = vecs[i].rt_val;
         #1;
         check({vecs[i].name, " D_ins"},  D_ins, vecs[i].ins);
         check({vecs[i].name, " D_PC"},   D_PC,  vecs[i].pc);
         check({vecs[i].name, " branch"}, 32'(branch), 32'(vecs[i].exp_br));
         if (vecs[i].chk_npc) check({vecs[i].name, " DnPC"}, DnPC, vecs[i].exp_npc);
         check({vecs[i].name, " D_link"}, D_link, vecs[i].pc + 32'd8);
         check({vecs[i].name, " D_rs"},   32'(D_rs), (vecs[i].ins >> 21) & 32'h1F);
         check({vecs[i].name, " D_rt"},   32'(D_rt), (vecs[i].ins >> 16) & 32'h1F);
      end

      // beq outcome follows operand updates while the instruction stays in D.
      F_ins = 32'h1085_0003; F_PC = 32'h0000_3000;
      step();
      D_rs_val = 32'd7; D_rt_val = 32'd7; #1;
      check("beq live eq branch", 32'(branch), 32'h1);
      check("beq live eq DnPC",   DnPC, 32'h0000_3010);
      D_rt_val = 32'd8; #1;
      check("beq live ne branch", 32'(branch), 32'h0);

      // Two stalled edges with changing fetch data, then release.
      stall = 1'b1;
      F_ins = 32'hAAAA_0001; F_PC = 32'h0000_4000; step();
      check("stall1 D_ins", D_ins, 32'h1085_0003);
      check("stall1 D_PC",  D_PC,  32'h0000_3000);
      F_ins = 32'hBBBB_0002; F_PC = 32'h0000_4004; step();
      check("stall2 D_ins", D_ins, 32'h1085_0003);
      check("stall2 D_PC",  D_PC,  32'h0000_3000);
      D_rt_val = 32'd7; #1;
      check("stall branch via operands", 32'(branch), 32'h1);
      stall = 1'b0;
      F_ins = 32'h0C00_0C00; F_PC = 32'h0000_4008; step();
      check("release D_ins", D_ins, 32'h0C00_0C00);
      check("release D_PC",  D_PC,  32'h0000_4008);

      // Reset and stall together: the bubble wins.
      reset = 1'b1; stall = 1'b1; step();
      check("rst+stall D_ins",  D_ins, 32'h0);
      check("rst+stall D_PC",   D_PC,  32'h0);
      check("rst+stall branch", 32'(branch), 32'h0);
      check("rst+stall DnPC",   DnPC,  32'h4);
      reset = 1'b0; stall = 1'b0;

      // Randomized traffic with random stalls, tracked by the model.
      exp_ins = 32'h0; exp_pc = 32'h0;
      for (int k = 0; k < 300; k++) begin
         w = $urandom();
         case ($urandom_range(0, 5))
            0: w = (w & 32'h03FF_FFFF) | (32'd4 << 26);
            1: w = (w & 32'h03FF_FFFF) | (32'd5 << 26);
            2: w = (w & 32'h03FF_FFFF) | (32'd2 << 26);
            3: w = (w & 32'h03FF_FFFF) | (32'd3 << 26);
            4: w = (w & 32'h03FF_FFC0) | 32'd8;
            default: ;
         endcase
         F_ins = w;
         F_PC  = $urandom() & 32'hFFFF_FFFC;
         stall = ($urandom_range(0, 3) == 0);
         if (!stall) begin
            exp_ins = F_ins;
            exp_pc  = F_PC;
         end
         step();
         a = $urandom();
         b = ($urandom_range(0, 1) == 1) ? a : $urandom();
         D_rs_val = a; D_rt_val = b; #1;
         model(exp_ins, exp_pc, a, b, mbr, mknown, mnpc);
         check("rand D_ins",   D_ins, exp_ins);
         check("rand D_PC",    D_PC,  exp_pc);
         check("rand branch",  32'(branch), 32'(mbr));
         if (mknown) check("rand DnPC", DnPC, mnpc);
         check("rand D_link",  D_link, exp_pc + 32'd8);
         check("rand D_rs",    32'(D_rs), (exp_ins >> 21) & 32'h1F);
         check("rand D_rt",    32'(D_rt), (exp_ins >> 16) & 32'h1F);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
